bicubic_output_normalizer: RTL and testbench
============================================

Name: bicubic_output_normalizer

Overview:
- Downstream neighbour of the stage-2 vector-times-weight-matrix multiplier.
- Accepts each group of four signed inner products (one interpolated 4-pixel output row segment) and applies round-half-up plus arithmetic right shift by the combined weight scale.
- Clamps each result to 8-bit [0,255], buffers groups in a 2-deep FIFO, and serialises them one pixel per beat on a valid/ready stream toward the output writer.

Parameters:
- PRODUCT_WIDTH, 32, width of each signed inner product.
- NORM_SHIFT, 14, right-shift that removes the stage-1 × stage-2 weight scale (2^7 × 2^7).
- PIXEL_WIDTH, 8, output pixel width; clamp ceiling is 2^PIXEL_WIDTH-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  group valid
- in_ready  out  1  group accepted when in_valid && in_ready at a rising edge
- in_last  in  1  group is the last of its output row
- inner_product1..4  in  PRODUCT_WIDTH each  signed two's-complement products; 1 is the leftmost pixel
- out_valid  out  1  pixel valid
- out_ready  in  1  downstream accepts
- out_pixel  out  PIXEL_WIDTH  normalised pixel
- out_last  out  1  high on the 4th pixel of an in_last group
- sat_count  out  16  present only with BICUBIC_SAT_CNT_EN

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers and count 0, pixel index 0, out_valid=0, out_pixel=0, out_last=0, in_ready=1 once released.
- Per product:
  - r = (ip + 2^(NORM_SHIFT-1)) >>> NORM_SHIFT, computed in PRODUCT_WIDTH+1 bits so no overflow.
  - r<0 → 0; r>255 → 255; otherwise r[7:0].
  - Computed combinationally on the inputs; only the 4 clamped bytes plus last bit are stored per entry (33 bits).
- FIFO:
  - 2 entries, registered occupancy count.
  - in_ready = (count<2); it depends only on registers, never combinationally on out_ready.
- Serialiser:
  - 2-bit pixel index selects a byte of the head entry.
  - out_valid = (count>0).
  - On out_valid && out_ready: index increments. When index==3, index wraps to 0 and the head is popped.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance. Allowed only when count==1.
- Latency: a group accepted at edge k with an empty FIFO presents pixel 0 with out_valid in the cycle after edge k.
- Throughput: sustained one group per 4 cycles.
- Pixel order: 1,2,3,4.
- out_valid and out_pixel stay stable while out_valid && !out_ready.
- out_last = head.last && index==3.
- in_valid low: no state change except draining.
- Values on inner_product* are ignored when no handshake occurs.
- Reset mid-group discards all buffered groups and the partial pixel index; no partial output resumes after reset.

Optional Feature:
- Macro: BICUBIC_SAT_CNT_EN.
- Defined:
  - sat_count port exists.
  - Counter increments by the number of products clamped (low or high) in each accepted group (0..4).
  - Saturates at 16'hFFFF, never wraps.
  - Cleared by rst.
- Not defined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package bicubic_pkg holds:
  - NORM_SHIFT default
  - PIXEL_WIDTH
  - PIXEL_MAX constant
  - rounding constant 2^(NORM_SHIFT-1)
- One sub-module, bicubic_round_clamp:
  - Purely combinational, one product in, one pixel out, plus a clamped flag.
  - Instantiated four times.
- FIFO and serialiser stay in the top module.

Test Plan:
- Single group ip={2097152, 0, 8191, 8192}, out_ready=1 → pixels 128, 0, 0, 1 on 4 consecutive cycles. out_valid rises the cycle after acceptance; out_last=0.
- Clamp: ip={-16384, 300×16384, 255×16384+8191, 256×16384-8193} → 0, 255, 255, 255. With BICUBIC_SAT_CNT_EN: sat_count=2.
- Backpressure: 3 groups offered back-to-back, out_ready=0.
  - in_ready drops after 2 accepts; out_pixel is held.
  - Releasing out_ready yields 12 pixels in order with no loss or duplication.
  - Third group is accepted the cycle after the first group's 4th pixel pops.
- in_last on 2nd of 2 groups, random out_ready toggling → out_last high only on pixel 8.
- Reset asserted mid-group (after pixel 1 of a 2-group backlog) → out_valid=0 immediately, count 0. A new group afterwards emits its pixel 0 first.
- Sat-counter saturation (feature on): force 16'hFFFE, then one group with 4 clamps → sat_count=16'hFFFF and holds there.

Source files
------------

// File: rtl/bicubic_pkg.sv
// Shared constants for the bicubic output normaliser.
// Defaults match a 2^7 x 2^7 combined weight scale and 8-bit pixels.
package bicubic_pkg;

   localparam int DEF_PRODUCT_WIDTH = 32;
   localparam int DEF_NORM_SHIFT    = 14;
   localparam int DEF_PIXEL_WIDTH   = 8;
   localparam int DEF_PIXEL_MAX     = (1 << DEF_PIXEL_WIDTH) - 1;
   localparam int DEF_ROUND         = 1 << (DEF_NORM_SHIFT - 1);

   localparam int GROUP_SIZE = 4;
   localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/bicubic_round_clamp.sv
// Round-half-up, arithmetic shift and clamp of one signed inner product.
// Purely combinational; flags whether the clamp engaged.
module bicubic_round_clamp
   import bicubic_pkg::*;
#(
   parameter int PRODUCT_WIDTH = DEF_PRODUCT_WIDTH,
   parameter int NORM_SHIFT    = DEF_NORM_SHIFT,
   parameter int PIXEL_WIDTH   = DEF_PIXEL_WIDTH
) (
   input  logic [PRODUCT_WIDTH-1:0] product,
   output logic [PIXEL_WIDTH-1:0]   pixel,
   output logic                     clamped
);

   localparam int W = PRODUCT_WIDTH + 1;
   localparam logic signed [W-1:0] RND  = W'(64'd1 << (NORM_SHIFT - 1));
   localparam logic signed [W-1:0] MAXV = W'((64'd1 << PIXEL_WIDTH) - 64'd1);

   logic signed [W-1:0] sum;
   logic signed [W-1:0] shifted;
   logic                neg;
   logic                high;

   // One extra bit keeps the rounding add from overflowing
   assign sum     = $signed({product[PRODUCT_WIDTH-1], product}) + RND;
   assign shifted = sum >>> NORM_SHIFT;
   assign neg     = shifted[W-1];
   assign high    = !neg && (shifted > MAXV);
   assign clamped = neg || high;

   always_comb begin
      pixel = shifted[PIXEL_WIDTH-1:0];
      if (neg) begin
         pixel = '0;
      end else if (high) begin
         pixel = MAXV[PIXEL_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/bicubic_output_normalizer.sv
// Normalises groups of four inner products into pixels, buffers two groups
// and serialises one pixel per beat. Optional BICUBIC_SAT_CNT_EN adds sat_count.
module bicubic_output_normalizer
   import bicubic_pkg::*;
#(
   parameter int PRODUCT_WIDTH = DEF_PRODUCT_WIDTH,
   parameter int NORM_SHIFT    = DEF_NORM_SHIFT,
   parameter int PIXEL_WIDTH   = DEF_PIXEL_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_last,
   input  logic [PRODUCT_WIDTH-1:0] inner_product1,
   input  logic [PRODUCT_WIDTH-1:0] inner_product2,
   input  logic [PRODUCT_WIDTH-1:0] inner_product3,
   input  logic [PRODUCT_WIDTH-1:0] inner_product4,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PIXEL_WIDTH-1:0]   out_pixel,
`ifdef BICUBIC_SAT_CNT_EN
   output logic [15:0]              sat_count,
`endif
   output logic                     out_last
);

   logic [PRODUCT_WIDTH-1:0] products [GROUP_SIZE];
   logic [GROUP_SIZE-1:0][PIXEL_WIDTH-1:0] pix_in;
   logic [GROUP_SIZE-1:0]    clamped;

   assign products[0] = inner_product1;
   assign products[1] = inner_product2;
   assign products[2] = inner_product3;
   assign products[3] = inner_product4;

   for (genvar g = 0; g < GROUP_SIZE; g++) begin : g_rc
      bicubic_round_clamp #(
         .PRODUCT_WIDTH (PRODUCT_WIDTH),
         .NORM_SHIFT    (NORM_SHIFT),
         .PIXEL_WIDTH   (PIXEL_WIDTH)
      ) u_rc (
         .product (products[g]),
         .pixel   (pix_in[g]),
         .clamped (clamped[g])
      );
   end

   logic [GROUP_SIZE-1:0][PIXEL_WIDTH-1:0] pix_mem [FIFO_DEPTH];
   logic                 last_mem [FIFO_DEPTH];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           count;
   logic [1:0]           idx;
   logic                 push;
   logic                 fire;
   logic                 pop;

   assign in_ready  = (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign fire      = out_valid && out_ready;
   assign pop       = fire && (idx == 2'd3);

   assign out_pixel = out_valid ? pix_mem[rd_ptr][idx] : '0;
   assign out_last  = out_valid && last_mem[rd_ptr] && (idx == 2'd3);

   // Storage needs no reset: occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         pix_mem[wr_ptr]  <= pix_in;
         last_mem[wr_ptr] <= in_last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         idx    <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (fire) begin
            idx <= idx + 2'd1;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`ifdef BICUBIC_SAT_CNT_EN
   logic [15:0] sat_q;
   logic [2:0]  clamp_n;
   logic [16:0] sat_sum;

   assign clamp_n = {2'b0, clamped[0]} + {2'b0, clamped[1]}
                  + {2'b0, clamped[2]} + {2'b0, clamped[3]};
   assign sat_sum = {1'b0, sat_q} + {14'b0, clamp_n};
   assign sat_count = sat_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_q <= 16'd0;
      end else if (push) begin
         sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
   end
`else
   logic unused_clamped;
   assign unused_clamped = ^clamped;
`endif

endmodule

// File: tb/tb_bicubic_output_normalizer.sv
// Scoreboard bench: driver queues expected pixels, monitor checks each beat.
module tb_bicubic_output_normalizer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_last = 1'b0;
   logic [31:0] ip1 = '0;
   logic [31:0] ip2 = '0;
   logic [31:0] ip3 = '0;
   logic [31:0] ip4 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_pixel;
   logic        out_last;
`ifdef BICUBIC_SAT_CNT_EN
   logic [15:0] sat_count;
`endif

   int errors = 0;
   int checks = 0;
   logic [8:0] exp_q [$];
   logic held_v = 1'b0;
   logic [7:0] held_px = '0;
   logic held_l = 1'b0;
   logic tog_done = 1'b0;

   always #5 clk = ~clk;

   bicubic_output_normalizer dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_last        (in_last),
      .inner_product1 (ip1),
      .inner_product2 (ip2),
      .inner_product3 (ip3),
      .inner_product4 (ip4),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pixel      (out_pixel),
`ifdef BICUBIC_SAT_CNT_EN
      .sat_count      (sat_count),
`endif
      .out_last       (out_last)
   );

   function automatic void chk(string nm, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endfunction

   // Monitor: compare every accepted beat and verify hold under stall
   always @(negedge clk) begin
      if (rst) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_pixel", int'(out_pixel), int'(held_px));
            chk("hold_last", int'(out_last), int'(held_l));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", int'(out_pixel), -1);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               chk("pixel", int'(out_pixel), int'(e[7:0]));
               chk("last", int'(out_last), int'(e[8]));
            end
         end
         held_v  = out_valid && !out_ready;
         held_px = out_pixel;
         held_l  = out_last;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input int a, input int b, input int c, input int d,
                       input logic l, input int p0, input int p1,
                       input int p2, input int p3);
      int n;
      logic ok;
      ip1 = a;
      ip2 = b;
      ip3 = c;
      ip4 = d;
      in_last = l;
      in_valid = 1'b1;
      n = 0;
      ok = 1'b0;
      while (!ok && n < 300) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else n++;
      end
      if (!ok) begin
         chk("accept_timeout", 0, 1);
      end else begin
         exp_q.push_back({1'b0, 8'(p0)});
         exp_q.push_back({1'b0, 8'(p1)});
         exp_q.push_back({1'b0, 8'(p2)});
         exp_q.push_back({l, 8'(p3)});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last = 1'b1;
      ip1 = 32'hDEADBEEF;
      ip2 = 32'h7FFFFFFF;
      ip3 = 32'h80000000;
      ip4 = 32'h12345678;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", int'(n >= 400), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_pixel", int'(out_pixel), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_in_ready", int'(in_ready), 1);
`ifdef BICUBIC_SAT_CNT_EN
      chk("rst_sat_count", int'(sat_count), 0);
`endif
      @(posedge clk);
      #1;

      // Single group with one-cycle latency
      out_ready = 1'b1;
      send(2097152, 0, 8191, 8192, 1'b0, 128, 0, 0, 1);
      chk("latency_valid", int'(out_valid), 1);
      chk("latency_pixel0", int'(out_pixel), 128);
      drain();

      // Clamping at both ends and just below the ceiling
      send(-16384, 300 * 16384, 255 * 16384 + 8191, 256 * 16384 - 8193,
           1'b0, 0, 255, 255, 255);
      drain();
`ifdef BICUBIC_SAT_CNT_EN
      chk("sat_after_clamp", int'(sat_count), 2);
`endif

      // Backpressure with three groups offered back to back
      out_ready = 1'b0;
      fork
         begin
            send(1 * 16384, 2 * 16384, 3 * 16384, 4 * 16384,
                 1'b0, 1, 2, 3, 4);
            send(10 * 16384, 20 * 16384, 30 * 16384, 40 * 16384,
                 1'b0, 10, 20, 30, 40);
            send(100 * 16384, 200 * 16384, 250 * 16384, 5 * 16384,
                 1'b0, 100, 200, 250, 5);
         end
      join_none
      repeat (4) @(posedge clk);
      #1;
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_pixel_held", int'(out_pixel), 1);
      repeat (2) @(posedge clk);
      #1;
      chk("bp_pixel_still", int'(out_pixel), 1);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 3) chk("bp_ready_before_pop", int'(in_ready), 0);
         if (i == 4) chk("bp_ready_after_pop", int'(in_ready), 1);
      end
      @(posedge clk);
      #1;
      drain();

      // in_last on the second group with random backpressure
      tog_done = 1'b0;
      fork
         begin
            while (!tog_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join_none
      send(50 * 16384, 60 * 16384, 70 * 16384, 80 * 16384,
           1'b0, 50, 60, 70, 80);
      send(90 * 16384, 100 * 16384, 110 * 16384, 120 * 16384,
           1'b1, 90, 100, 110, 120);
      drain();
      tog_done = 1'b1;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset in the middle of a two-group backlog
      out_ready = 1'b0;
      send(11 * 16384, 12 * 16384, 13 * 16384, 14 * 16384,
           1'b0, 11, 12, 13, 14);
      send(21 * 16384, 22 * 16384, 23 * 16384, 24 * 16384,
           1'b0, 21, 22, 23, 24);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_pixel", int'(out_pixel), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("postrst_valid", int'(out_valid), 0);
      chk("postrst_in_ready", int'(in_ready), 1);
`ifdef BICUBIC_SAT_CNT_EN
      chk("postrst_sat", int'(sat_count), 0);
`endif
      out_ready = 1'b1;
      send(7 * 16384, 8 * 16384, 9 * 16384, 10 * 16384,
           1'b0, 7, 8, 9, 10);
      chk("postrst_first_pixel", int'(out_pixel), 7);
      drain();

`ifdef BICUBIC_SAT_CNT_EN
      // Saturating counter
      force dut.sat_q = 16'hFFFE;
      #1;
      release dut.sat_q;
      @(posedge clk);
      #1;
      send(-32768, -32768, 1000 * 16384, 1000 * 16384,
           1'b0, 0, 0, 255, 255);
      chk("sat_reach_max", int'(sat_count), 65535);
      send(-32768, -32768, 1000 * 16384, 1000 * 16384,
           1'b0, 0, 0, 255, 255);
      chk("sat_hold_max", int'(sat_count), 65535);
      drain();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
